// File: rtl/boxhead_pkg.sv
// boxhead_pkg: shared definitions for the boxhead game objects.
//   - Sprite direction encoding (DIR_DOWN/LEFT/UP/RIGHT), matching the
//     player object so the sprite ROM layout is common.
//   - Playfield bounds: X 1..319, Y 52..205 (upper-left coordinates
//     before subtracting the sprite size).
//   - zombie_state_t life-cycle states.
//   - Small helpers for clamping and signed magnitude.
package boxhead_pkg;

    localparam logic [1:0] DIR_DOWN  = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [8:0] FIELD_X_MIN = 9'd1;
    localparam logic [8:0] FIELD_X_MAX = 9'd319;
    localparam logic [8:0] FIELD_Y_MIN = 9'd52;
    localparam logic [8:0] FIELD_Y_MAX = 9'd205;

    // Frame ticks a dead zombie stays visible before disappearing.
    localparam logic [7:0] DYING_FRAMES = 8'd4;

    typedef enum logic [1:0] {
        SPAWN = 2'd0,
        CHASE = 2'd1,
        HURT  = 2'd2,
        DYING = 2'd3
    } zombie_state_t;

    function automatic logic [8:0] clamp9(input logic [8:0] v,
                                          input logic [8:0] lo,
                                          input logic [8:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic [9:0] abs10(input logic signed [9:0] v);
        return v[9] ? 10'(-v) : 10'(v);
    endfunction

endpackage

// File: rtl/chase_step.sv
// chase_step: combinational one-frame pursuit step toward a target.
// Build option: ZOMBIE_DIAGONAL_EN -- when defined both axes move in the
// same frame; otherwise only the axis with the larger distance moves.
// Ports:
//   cur_x/cur_y   current upper-left position
//   tgt_x/tgt_y   target upper-left position
//   step          maximum pixels moved per axis per frame
//   x_min..y_max  inclusive clamp bounds for the result
//   cur_dir       direction held when already on target
//   nxt_x/nxt_y   next position (never overshoots the target)
//   nxt_dir       direction of the dominant axis of motion
//   moved         next position differs from the current one
module chase_step
    import boxhead_pkg::*;
(
    input  logic [8:0] cur_x,
    input  logic [8:0] cur_y,
    input  logic [8:0] tgt_x,
    input  logic [8:0] tgt_y,
    input  logic [8:0] step,
    input  logic [8:0] x_min,
    input  logic [8:0] x_max,
    input  logic [8:0] y_min,
    input  logic [8:0] y_max,
    input  logic [1:0] cur_dir,
    output logic [8:0] nxt_x,
    output logic [8:0] nxt_y,
    output logic [1:0] nxt_dir,
    output logic       moved
);

    logic signed [9:0] dx;
    logic signed [9:0] dy;
    logic [9:0] ax;
    logic [9:0] ay;
    logic [8:0] mag_x;
    logic [8:0] mag_y;
    logic [8:0] step_x;
    logic [8:0] step_y;
    logic       use_x;
    logic       at_target;

    always_comb begin
        dx = signed'({1'b0, tgt_x}) - signed'({1'b0, cur_x});
        dy = signed'({1'b0, tgt_y}) - signed'({1'b0, cur_y});
        ax = abs10(dx);
        ay = abs10(dy);

        // Capping the step at the remaining distance prevents overshoot;
        // it also keeps cur +/- mag inside 0..511, so 9 bits cannot wrap.
        mag_x = (ax < {1'b0, step}) ? ax[8:0] : step;
        mag_y = (ay < {1'b0, step}) ? ay[8:0] : step;
        step_x = dx[9] ? (cur_x - mag_x) : (cur_x + mag_x);
        step_y = dy[9] ? (cur_y - mag_y) : (cur_y + mag_y);

        use_x     = (ax >= ay);  // ties favour X
        at_target = (ax == 10'd0) && (ay == 10'd0);

        nxt_x   = cur_x;
        nxt_y   = cur_y;
        nxt_dir = cur_dir;
        if (!at_target) begin
`ifdef ZOMBIE_DIAGONAL_EN
            nxt_x = step_x;
            nxt_y = step_y;
`else
            if (use_x) begin
                nxt_x = step_x;
            end else begin
                nxt_y = step_y;
            end
`endif
            if (use_x) begin
                nxt_dir = dx[9] ? DIR_LEFT : DIR_RIGHT;
            end else begin
                nxt_dir = dy[9] ? DIR_UP : DIR_DOWN;
            end
        end

        nxt_x = clamp9(nxt_x, x_min, x_max);
        nxt_y = clamp9(nxt_y, y_min, y_max);
        moved = (nxt_x != cur_x) || (nxt_y != cur_y);
    end

endmodule

// File: rtl/zombie.sv
// zombie: enemy object that walks toward the player once per game frame.
// Owns position, hit points and the SPAWN/CHASE/HURT/DYING life cycle, and
// drives the same pixel-hit / sprite-address interface as the player.
// Build option: ZOMBIE_DIAGONAL_EN (see chase_step) enables diagonal moves.
// Ports:
//   Clk, Reset_n                 clock, asynchronous active-low reset
//   game_frame_clk_rising_edge   one-Clk pulse per game frame
//   Player_X_Pos/Player_Y_Pos    player upper-left position
//   Hit                          one-Clk pulse from bullet collision logic
//   PixelX/PixelY                pixel currently being drawn
//   is_obj                       pixel lies inside the visible zombie
//   Obj_address                  sprite ROM address for that pixel
//   Obj_X_Pos/Obj_Y_Pos          zombie upper-left position
//   Obj_Direction                0 down, 1 left, 2 up, 3 right
//   Contact                      zombie box overlaps the player box
//   Killed                       one-Clk pulse when HP reaches zero
module zombie
    import boxhead_pkg::*;
#(
    parameter logic [8:0] SPAWN_X        = 9'd10,
    parameter logic [8:0] SPAWN_Y        = 9'd60,
    parameter logic [8:0] WIDTH          = 9'd18,
    parameter logic [8:0] HEIGHT         = 9'd20,
    parameter logic [8:0] STEP           = 9'd1,
    parameter logic [1:0] MAX_HP         = 2'd3,
    parameter logic [7:0] RESPAWN_FRAMES = 8'd120,
    parameter logic [3:0] HURT_FRAMES    = 4'd8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        game_frame_clk_rising_edge,
    input  logic [8:0]  Player_X_Pos,
    input  logic [8:0]  Player_Y_Pos,
    input  logic        Hit,
    input  logic [8:0]  PixelX,
    input  logic [8:0]  PixelY,
    output logic        is_obj,
    output logic [12:0] Obj_address,
    output logic [8:0]  Obj_X_Pos,
    output logic [8:0]  Obj_Y_Pos,
    output logic [1:0]  Obj_Direction,
    output logic        Contact,
    output logic        Killed
);

    localparam logic [8:0]  X_MAX       = FIELD_X_MAX - WIDTH;
    localparam logic [8:0]  Y_MAX       = FIELD_Y_MAX - HEIGHT;
    localparam logic [12:0] SPRITE_SIZE = 13'(WIDTH) * 13'(HEIGHT);

    zombie_state_t state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;      // shared spawn / hurt / dying frame counter
    logic [8:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic [1:0]    dir_q, dir_d;
    logic [1:0]    hp_q, hp_d;
    logic [1:0]    step_q, step_d;    // walk-animation step count
    logic          killed_q, killed_d;

    logic [8:0]    chase_x;
    logic [8:0]    chase_y;
    logic [1:0]    chase_dir;
    logic          chase_moved;

    chase_step u_chase_step (
        .cur_x   (x_q),
        .cur_y   (y_q),
        .tgt_x   (Player_X_Pos),
        .tgt_y   (Player_Y_Pos),
        .step    (STEP),
        .x_min   (FIELD_X_MIN),
        .x_max   (X_MAX),
        .y_min   (FIELD_Y_MIN),
        .y_max   (Y_MAX),
        .cur_dir (dir_q),
        .nxt_x   (chase_x),
        .nxt_y   (chase_y),
        .nxt_dir (chase_dir),
        .moved   (chase_moved)
    );

    always_comb begin
        // NOTE: every *_d starts from its *_q so no path through the case
        // leaves a signal unassigned and infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        hp_d     = hp_q;
        step_d   = step_q;
        killed_d = 1'b0;

        case (state_q)
            SPAWN: begin
                if (game_frame_clk_rising_edge) begin
                    // Counter stops at the limit; the next tick starts the chase.
                    if (cnt_q >= RESPAWN_FRAMES) begin
                        state_d = CHASE;
                        cnt_d   = '0;
                        x_d     = SPAWN_X;
                        y_d     = SPAWN_Y;
                        dir_d   = DIR_DOWN;
                        hp_d    = MAX_HP;
                        step_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            CHASE: begin
                // A hit in the same cycle as a frame tick suppresses the move.
                if (Hit) begin
                    cnt_d = '0;
                    if (hp_q <= 2'd1) begin
                        hp_d     = '0;
                        state_d  = DYING;
                        killed_d = 1'b1;
                    end else begin
                        hp_d    = hp_q - 2'd1;
                        state_d = HURT;
                    end
                end else if (game_frame_clk_rising_edge) begin
                    x_d   = chase_x;
                    y_d   = chase_y;
                    dir_d = chase_dir;
                    if (chase_moved) begin
                        step_d = step_q + 2'd1;
                    end
                end
            end
            HURT: begin
                if (game_frame_clk_rising_edge) begin
                    if (cnt_q + 8'd1 >= {4'd0, HURT_FRAMES}) begin
                        state_d = CHASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            DYING: begin
                if (game_frame_clk_rising_edge) begin
                    if (cnt_q + 8'd1 >= DYING_FRAMES) begin
                        state_d = SPAWN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = SPAWN;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= SPAWN;
            cnt_q    <= '0;
            x_q      <= SPAWN_X;
            y_q      <= SPAWN_Y;
            dir_q    <= DIR_DOWN;
            hp_q     <= MAX_HP;
            step_q   <= '0;
            killed_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the values
            // from before this edge regardless of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
            hp_q     <= hp_d;
            step_q   <= step_d;
            killed_q <= killed_d;
        end
    end

    assign Obj_X_Pos     = x_q;
    assign Obj_Y_Pos     = y_q;
    assign Obj_Direction = dir_q;
    assign Killed        = killed_q;

    // Pixel hit, sprite address and player overlap, all from registered state.
    logic [9:0] x_end;
    logic [9:0] y_end;
    logic [9:0] px_end;
    logic [9:0] py_end;
    logic [8:0] dist_x;
    logic [8:0] dist_y;
    logic [1:0] frame_sel;
    logic       in_box;

    always_comb begin
        x_end  = {1'b0, x_q} + {1'b0, WIDTH};
        y_end  = {1'b0, y_q} + {1'b0, HEIGHT};
        px_end = {1'b0, Player_X_Pos} + {1'b0, WIDTH};
        py_end = {1'b0, Player_Y_Pos} + {1'b0, HEIGHT};
        dist_x = PixelX - x_q;
        dist_y = PixelY - y_q;

        in_box = (PixelX >= x_q) && ({1'b0, PixelX} < x_end) &&
                 (PixelY >= y_q) && ({1'b0, PixelY} < y_end);

        // Frame 3 is the hurt pose; walking alternates 0,1,0,2 over the step count.
        if (state_q == HURT || state_q == DYING) begin
            frame_sel = 2'd3;
        end else if (!step_q[0]) begin
            frame_sel = 2'd0;
        end else begin
            frame_sel = 2'd1 + {1'b0, step_q[1]};
        end

        is_obj = in_box && (state_q != SPAWN);
        if (is_obj) begin
            Obj_address = 13'(dist_x) + 13'(dist_y) * 13'(WIDTH)
                        + SPRITE_SIZE * 13'({dir_q, frame_sel});
        end else begin
            Obj_address = '0;
        end

        Contact = ((state_q == CHASE) || (state_q == HURT)) &&
                  ({1'b0, x_q} < px_end) && ({1'b0, Player_X_Pos} < x_end) &&
                  ({1'b0, y_q} < py_end) && ({1'b0, Player_Y_Pos} < y_end);
    end

endmodule

// File: tb/tb_zombie.sv
// tb_zombie: self-checking bench for zombie (default single-axis build).
// Two instances share clock, reset and pixel inputs: u_a walks 1 px/frame,
// u_b walks 9 px/frame. Moves are predicted by a small bench model and
// queued as expectations, then compared once the DUT has taken the tick.
module tb_zombie;

    localparam int SPR = 360;  // 18 x 20 sprite frame size

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_a = 1'b0;
    logic        frame_b = 1'b0;
    logic        hit_a = 1'b0;
    logic        hit_b = 1'b0;
    logic [8:0]  pl_a_x, pl_a_y, pl_b_x, pl_b_y;
    logic [8:0]  pix_x, pix_y;

    logic        is_obj_a, is_obj_b, contact_a, contact_b, killed_a, killed_b;
    logic [12:0] addr_a, addr_b;
    logic [8:0]  x_a, y_a, x_b, y_b;
    logic [1:0]  dir_a, dir_b;

    always #10 Clk = ~Clk;

    zombie #(.STEP(9'd1)) u_a (
        .Clk(Clk), .Reset_n(Reset_n), .game_frame_clk_rising_edge(frame_a),
        .Player_X_Pos(pl_a_x), .Player_Y_Pos(pl_a_y), .Hit(hit_a),
        .PixelX(pix_x), .PixelY(pix_y), .is_obj(is_obj_a), .Obj_address(addr_a),
        .Obj_X_Pos(x_a), .Obj_Y_Pos(y_a), .Obj_Direction(dir_a),
        .Contact(contact_a), .Killed(killed_a)
    );

    zombie #(.STEP(9'd9)) u_b (
        .Clk(Clk), .Reset_n(Reset_n), .game_frame_clk_rising_edge(frame_b),
        .Player_X_Pos(pl_b_x), .Player_Y_Pos(pl_b_y), .Hit(hit_b),
        .PixelX(pix_x), .PixelY(pix_y), .is_obj(is_obj_b), .Obj_address(addr_b),
        .Obj_X_Pos(x_b), .Obj_Y_Pos(y_b), .Obj_Direction(dir_b),
        .Contact(contact_b), .Killed(killed_b)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int x;
        int y;
        int dir;
        int addr;
    } exp_t;
    exp_t sb[$];

    int m_x[2];
    int m_y[2];
    int m_dir[2];
    int m_step[2];

    typedef struct {
        int pl_x;
        int pl_y;
        int px;
        int py;
        int obj;
        int addr;
        int contact;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input bit use_a, input bit use_b);
        frame_a = use_a;
        frame_b = use_b;
        @(posedge Clk);
        #1;
        frame_a = 1'b0;
        frame_b = 1'b0;
    endtask

    task automatic pulse_hit_a();
        hit_a = 1'b1;
        @(posedge Clk);
        #1;
        hit_a = 1'b0;
    endtask

    function automatic int walk_frame(input int step_cnt);
        if (step_cnt % 2 == 0) return 0;
        return (step_cnt == 1) ? 1 : 2;
    endfunction

    // Predict one chase frame for instance sel, queue it, tick, then compare.
    task automatic move_tick(input int sel, input int step_px);
        exp_t e;
        int px, py, dx, dy, ax, ay, m, nx, ny;
        px = (sel == 1) ? int'(pl_b_x) : int'(pl_a_x);
        py = (sel == 1) ? int'(pl_b_y) : int'(pl_a_y);
        nx = m_x[sel];
        ny = m_y[sel];
        dx = px - nx;
        dy = py - ny;
        ax = (dx < 0) ? -dx : dx;
        ay = (dy < 0) ? -dy : dy;
        if (ax != 0 || ay != 0) begin
            if (ax >= ay) begin
                m = (ax < step_px) ? ax : step_px;
                nx = (dx > 0) ? nx + m : nx - m;
                m_dir[sel] = (dx > 0) ? 3 : 1;
            end else begin
                m = (ay < step_px) ? ay : step_px;
                ny = (dy > 0) ? ny + m : ny - m;
                m_dir[sel] = (dy > 0) ? 0 : 2;
            end
            if (nx < 1) nx = 1;
            if (nx > 301) nx = 301;
            if (ny < 52) ny = 52;
            if (ny > 185) ny = 185;
            if (nx != m_x[sel] || ny != m_y[sel]) m_step[sel] = (m_step[sel] + 1) % 4;
            m_x[sel] = nx;
            m_y[sel] = ny;
        end
        e.x = m_x[sel];
        e.y = m_y[sel];
        e.dir = m_dir[sel];
        e.addr = SPR * (4 * m_dir[sel] + walk_frame(m_step[sel]));
        sb.push_back(e);

        tick(sel == 0, sel == 1);

        e = sb.pop_front();
        pix_x = 9'(e.x);
        pix_y = 9'(e.y);
        #1;
        if (sel == 1) begin
            check("b_x", 32'(x_b), e.x);
            check("b_y", 32'(y_b), e.y);
            check("b_dir", 32'(dir_b), e.dir);
            check("b_addr", 32'(addr_b), e.addr);
        end else begin
            check("a_x", 32'(x_a), e.x);
            check("a_y", 32'(y_a), e.y);
            check("a_dir", 32'(dir_a), e.dir);
            check("a_addr", 32'(addr_a), e.addr);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            m_x[s] = 10; m_y[s] = 60; m_dir[s] = 0; m_step[s] = 0;
        end
        // {player x, player y, pixel x, pixel y, is_obj, address, contact}
        // with u_a at (14,60), facing right, step count 0.
        vecs[0] = '{100, 60, 14, 60, 1, 4320, 0};
        vecs[1] = '{31, 79, 31, 79, 1, 4679, 1};
        vecs[2] = '{32, 60, 32, 60, 0, 0, 0};
        vecs[3] = '{0, 41, 13, 60, 0, 0, 1};
        vecs[4] = '{0, 40, 14, 80, 0, 0, 0};
        vecs[5] = '{20, 60, 20, 65, 1, 4416, 1};

        pl_a_x = 9'd100; pl_a_y = 9'd60;
        pl_b_x = 9'd10;  pl_b_y = 9'd65;
        pix_x  = 9'd10;  pix_y  = 9'd60;

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        check("rst_x", 32'(x_a), 10);
        check("rst_y", 32'(y_a), 60);
        check("rst_dir", 32'(dir_a), 0);
        check("rst_is_obj", 32'(is_obj_a), 0);
        check("rst_addr", 32'(addr_a), 0);
        check("rst_contact", 32'(contact_b), 0);
        check("rst_killed", 32'(killed_a), 0);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // Spawn delay: invisible through 120 ticks, chasing after the 121st
        repeat (120) tick(1'b1, 1'b1);
        check("spawn120_a_obj", 32'(is_obj_a), 0);
        check("spawn120_b_obj", 32'(is_obj_b), 0);
        check("spawn120_b_contact", 32'(contact_b), 0);
        tick(1'b1, 1'b1);
        check("spawn121_a_obj", 32'(is_obj_a), 1);
        check("spawn121_a_addr", 32'(addr_a), 0);
        check("spawn121_b_x", 32'(x_b), 10);
        check("spawn121_b_y", 32'(y_b), 60);
        check("spawn121_b_contact", 32'(contact_b), 1);

        // 1 px/frame walk right: step count 0,1,2,3,0 seen through the frame
        repeat (4) move_tick(0, 1);

        // Combinational pixel / address / contact table
        for (int i = 0; i < 6; i++) begin
            pl_a_x = 9'(vecs[i].pl_x);
            pl_a_y = 9'(vecs[i].pl_y);
            pix_x  = 9'(vecs[i].px);
            pix_y  = 9'(vecs[i].py);
            #1;
            check($sformatf("tbl%0d_obj", i), 32'(is_obj_a), vecs[i].obj);
            check($sformatf("tbl%0d_addr", i), 32'(addr_a), vecs[i].addr);
            check($sformatf("tbl%0d_contact", i), 32'(contact_a), vecs[i].contact);
        end

        // 9 px/frame: lands exactly on Y=65, then a frame with no move
        move_tick(1, 9);
        move_tick(1, 9);
        pl_b_x = 9'd40; pl_b_y = 9'd65;
        repeat (4) move_tick(1, 9);
        pl_b_x = 9'd20; pl_b_y = 9'd60;
        repeat (4) move_tick(1, 9);
        pix_x = 9'd21; pix_y = 9'd61;
        #1;
        check("sprite_b_obj", 32'(is_obj_b), 1);
        check("sprite_b_addr", 32'(addr_b), 1819);

        // Hit together with a frame tick: no move, hurt pose
        hit_a = 1'b1;
        frame_a = 1'b1;
        @(posedge Clk);
        #1;
        hit_a = 1'b0;
        frame_a = 1'b0;
        pix_x = 9'd14; pix_y = 9'd60;
        #1;
        check("hit_tick_x", 32'(x_a), 14);
        check("hit_tick_addr", 32'(addr_a), SPR * 15);
        check("hit_tick_killed", 32'(killed_a), 0);
        check("hurt_contact", 32'(contact_a), 1);

        // Hit while hurt is ignored
        pulse_hit_a();
        check("hurt_hit_killed", 32'(killed_a), 0);
        repeat (7) tick(1'b1, 1'b0);
        check("hurt_frozen_x", 32'(x_a), 14);
        check("hurt_frozen_addr", 32'(addr_a), SPR * 15);
        repeat (3) tick(1'b1, 1'b0);
        check("hurt_over_moved", 32'(x_a != 9'd14), 1);

        // Second counted hit: still alive
        pulse_hit_a();
        check("hit3_killed", 32'(killed_a), 0);
        repeat (10) tick(1'b1, 1'b0);

        // Final hit: Killed for exactly one cycle, then DYING for 4 ticks
        pulse_hit_a();
        check("kill_pulse", 32'(killed_a), 1);
        @(posedge Clk);
        #1;
        check("kill_pulse_end", 32'(killed_a), 0);
        pix_x = 9'd25; pix_y = 9'd65;
        #1;
        check("dying_obj", 32'(is_obj_a), 1);
        check("dying_contact", 32'(contact_a), 0);
        repeat (3) tick(1'b1, 1'b0);
        check("dying3_obj", 32'(is_obj_a), 1);
        tick(1'b1, 1'b0);
        check("dying4_obj", 32'(is_obj_a), 0);

        // Asynchronous reset in the middle of a chase
        pix_x = 9'd21; pix_y = 9'd61;
        #5;
        Reset_n = 1'b0;
        #1;
        check("arst_x", 32'(x_b), 10);
        check("arst_y", 32'(y_b), 60);
        check("arst_dir", 32'(dir_b), 0);
        check("arst_obj", 32'(is_obj_b), 0);
        check("arst_contact", 32'(contact_b), 0);
        #20;
        Reset_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zombie.md
# zombie

Enemy object that reads the player's position each game frame and walks toward it. It owns its own position, hit points, and life-cycle state machine: spawn delay, chase, hurt, dying. It drives the same pixel-hit and sprite-address interface as the player object, so the sprite ROM and colour mapper consume both identically. One instance per enemy; instances sit beside the player in the game top level.

## Interface
Parameters:
- SPAWN_X, 9'd10: spawn upper-left X.
- SPAWN_Y, 9'd60: spawn upper-left Y.
- WIDTH, 9'd18: sprite width.
- HEIGHT, 9'd20: sprite height.
- STEP, 9'd1: pixels moved per frame.
- MAX_HP, 2'd3: hits to kill.
- RESPAWN_FRAMES, 8'd120: frames invisible before chasing.
- HURT_FRAMES, 4'd8: frames frozen after a hit.

Ports:
- Clk, in, 1: 50 MHz clock.
- Reset_n, in, 1: asynchronous, active-low reset.
- game_frame_clk_rising_edge, in, 1: one-Clk pulse per game frame.
- Player_X_Pos, Player_Y_Pos, in, 9 each: player upper-left position.
- Hit, in, 1: one-Clk pulse from bullet collision logic.
- PixelX, PixelY, in, 9 each: current pixel.
- is_obj, out, 1: current pixel lies inside the visible zombie.
- Obj_address, out, 13: sprite ROM address.
- Obj_X_Pos, Obj_Y_Pos, out, 9 each: upper-left position.
- Obj_Direction, out, 2: 0 down, 1 left, 2 up, 3 right.
- Contact, out, 1: zombie bounding box overlaps the player box (player box assumed WIDTH×HEIGHT).
- Killed, out, 1: one-Clk pulse when HP reaches 0.

## Operation
States:
- SPAWN: invisible. Counts frame ticks; after RESPAWN_FRAMES ticks, goes to CHASE with position at spawn, HP = MAX_HP, Direction = 0.
- CHASE: on each frame tick, compute dx = Player_X − Obj_X and dy = Player_Y − Obj_Y, signed 10-bit.
  - Move along the axis with the larger |d|; ties go to X.
  - Move by min(STEP, |d|), so the zombie never overshoots.
  - Set Direction to match the move.
  - Clamp X to 1..(319−WIDTH) and Y to 52..(205−HEIGHT).
  - If dx = dy = 0, no move and Direction is held.
  - The 2-bit step count increments only on frames where the zombie actually moved.
- Hit in CHASE: HP −1. If HP becomes 0, go to DYING and pulse Killed; otherwise go to HURT.
- HURT: no movement for HURT_FRAMES ticks, then return to CHASE. Hit is ignored.
- DYING: visible and frozen for 4 ticks, then SPAWN with the counter cleared. Hit is ignored.

Sprite address, with DistX = PixelX − Obj_X and DistY = PixelY − Obj_Y:
- Address = DistX + DistY·WIDTH + WIDTH·HEIGHT·(4·Direction + f).
- f = 3 in HURT and DYING.
- Otherwise f = 0 if step[0] = 0, else f = 1 + step[1].
- Outside the box, or in SPAWN: is_obj = 0 and Obj_address = 0.

Contact is forced to 0 in SPAWN and DYING.

## Timing
- Reset values: state SPAWN; spawn counter 0; Obj_X_Pos/Obj_Y_Pos = SPAWN_X/SPAWN_Y; Direction 0; HP = MAX_HP; step count 0; Killed 0; is_obj 0; Contact 0.
- Position, direction, and state update on the Clk edge that samples the frame tick. Outputs reflect the new values the following cycle.
- Hit is registered the same cycle it is sampled. Killed is asserted the cycle after the Hit pulse, for exactly one cycle.
- Hit and frame tick in the same cycle in CHASE: Hit wins and there is no movement that frame.
- is_obj, Obj_address, and Contact are combinational from registered state and the pixel/player inputs, with zero latency.
- Reset_n asserted mid-chase returns all state to reset values immediately (asynchronous).
- The spawn and hurt counters saturate at their limits; they never wrap.

## Configuration
- ZOMBIE_DIAGONAL_EN defined: in CHASE, X and Y each move by min(STEP, |d|) in the same frame. Direction follows the axis with the larger |d| (ties go to X).
- Not defined: single-axis movement as described under Operation.

## Structure
- boxhead_pkg holds:
  - direction encoding constants DIR_DOWN/LEFT/UP/RIGHT;
  - playfield bounds (X 1..319, Y 52..205);
  - zombie_state_t enum {SPAWN, CHASE, HURT, DYING}.
- One sub-module, chase_step: combinational. Takes current position, target, STEP, and bounds; returns next position, direction, and a moved flag. It is reused by future enemy types.

## Test plan
- Reset, then 120 frame ticks → still SPAWN, is_obj 0. Tick 121 → CHASE at (10,60).
- Player at (100,60), zombie at (10,60), STEP 1 → X = 11, Direction 3 after one tick; step count cycles 0,1,2,3,0.
- Player at (10,65), zombie at (10,60), STEP 9 → Y = 65 exactly (no overshoot), Direction 0. A further tick produces no move and step count is unchanged.
- Three Hit pulses spaced more than 8 ticks apart → HURT twice, then Killed pulses for one cycle. DYING lasts 4 ticks, then SPAWN.
- Hit coinciding with a frame tick → position unchanged and HP decremented. A second Hit during HURT → HP unchanged.
- Zombie at (20,60), PixelX/PixelY = (21,61), Direction 1, step count 1 → is_obj 1, address = 1 + 18 + 360·5 = 1819.
